int_ctrl: RTL and testbench

Interrupt controller feeding the pipeline controller's `int_ask` input. It edge-detects external interrupt lines into sticky pending bits and applies a mask and a global enable. It selects the lowest-numbered eligible interrupt, requests a pipeline flush, saves the return PC, redirects fetch to the interrupt vector, and blocks further interrupts until the handler retires `reti`.

---
 rtl/int_pkg.sv | 19 +
 rtl/prio_enc.sv | 23 ++
 rtl/int_ctrl.sv | 128 ++++++++++++
 tb/tb_int_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and defaults for the interrupt controller and related blocks.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        SERVICE  = 2'd3
    } state_e;

    localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0100;
    localparam int unsigned VEC_SHIFT_DEF = 2;

    // Index width for n sources; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder; bit 0 has the highest priority.
module prio_enc #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected sticky pending bits, mask/global enable,
// fixed-priority selection, flush handshake, EPC save and fetch redirect.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned          IRQ_NUM   = 8,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    VEC_BASE  = ADDR_W'(VEC_BASE_DEF),
    parameter int unsigned          VEC_SHIFT = VEC_SHIFT_DEF,
    localparam int unsigned         ID_W      = idx_w(IRQ_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_NUM-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [IRQ_NUM-1:0] mask_data,
    input  logic               gie_wr,
    input  logic               gie_data,
    input  logic               pipe_stall,
    input  logic [ADDR_W-1:0]  cur_pc,
    input  logic               reti,
    output logic               int_ask,
    output logic               int_vec_valid,
    output logic [ADDR_W-1:0]  int_vec,
    output logic [ADDR_W-1:0]  epc,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service
);

    state_e              state_q;
    state_e              state_d;
    logic [IRQ_NUM-1:0]  irq_q;
    logic [IRQ_NUM-1:0]  pending;
    logic [IRQ_NUM-1:0]  mask;
    logic                gie;
    logic [IRQ_NUM-1:0]  elig;
    logic [IRQ_NUM-1:0]  rise;
    logic [IRQ_NUM-1:0]  clr_vec;
    logic [ID_W-1:0]     sel_id;
    logic                sel_found;
    logic                take;
    logic                leave_flush;
    logic [ADDR_W-1:0]   vec_next;

    assign elig     = pending & ~mask;
    assign rise     = irq_in & ~irq_q;
    assign clr_vec  = leave_flush ? (IRQ_NUM'(1) << int_id) : '0;
    assign vec_next = VEC_BASE + (ADDR_W'(int_id) << VEC_SHIFT);

    prio_enc #(
        .N (IRQ_NUM),
        .W (ID_W)
    ) u_prio_enc (
        .req   (elig),
        .idx   (sel_id),
        .found (sel_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        take        = 1'b0;
        leave_flush = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gie && sel_found) begin
                    take    = 1'b1;
                    state_d = FLUSH;
                end
            end
            // The pipeline gives stall priority over the interrupt flush.
            FLUSH: begin
                if (!pipe_stall) begin
                    leave_flush = 1'b1;
                    state_d     = REDIRECT;
                end
            end
            REDIRECT: state_d = SERVICE;
            SERVICE: begin
                if (reti) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on the line being cleared wins, keeping it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '1;
            gie     <= 1'b0;
            epc     <= '0;
            int_id  <= '0;
            int_vec <= VEC_BASE;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clr_vec) | rise;
            if (mask_wr) begin
                mask <= mask_data;
            end
            if (gie_wr) begin
                gie <= gie_data;
            end
            if (take) begin
                int_id <= sel_id;
            end
            if (leave_flush) begin
                epc     <= cur_pc;
                int_vec <= vec_next;
            end
        end
    end

    assign int_ask       = (state_q == FLUSH);
    assign int_vec_valid = (state_q == REDIRECT);
    assign in_service    = (state_q != IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: redirect scoreboard plus per-scenario timing checks.
module tb_int_ctrl;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] epc;
        logic [2:0]  id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        mask_wr;
    logic [7:0]  mask_data;
    logic        gie_wr;
    logic        gie_data;
    logic        pipe_stall;
    logic [31:0] cur_pc;
    logic        reti;
    logic        int_ask;
    logic        int_vec_valid;
    logic [31:0] int_vec;
    logic [31:0] epc;
    logic [2:0]  int_id;
    logic        in_service;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_in        (irq_in),
        .mask_wr       (mask_wr),
        .mask_data     (mask_data),
        .gie_wr        (gie_wr),
        .gie_data      (gie_data),
        .pipe_stall    (pipe_stall),
        .cur_pc        (cur_pc),
        .reti          (reti),
        .int_ask       (int_ask),
        .int_vec_valid (int_vec_valid),
        .int_vec       (int_vec),
        .epc           (epc),
        .int_id        (int_id),
        .in_service    (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every redirect must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && int_vec_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_redirect: vec=%h epc=%h id=%0d, none expected", int_vec, epc, int_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int_vec !== e.vec || epc !== e.epc || int_id !== e.id) begin
                    n_fail++;
                    $display("FAIL sb_redirect: got vec=%h epc=%h id=%0d, want vec=%h epc=%h id=%0d",
                             int_vec, epc, int_id, e.vec, e.epc, e.id);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [31:0] pc);
        exp_t e;
        e.vec = 32'h0000_0100 + 32'(id) * 32'd4;
        e.epc = pc;
        e.id  = id;
        sb.push_back(e);
    endtask

    // Negedges until int_ask is seen; returns max+1 when it never rises.
    task automatic wait_ask(input int max, output int n);
        n = 0;
        while (n < max) begin
            tick();
            n++;
            if (int_ask) return;
        end
        n = max + 1;
    endtask

    // From the first int_ask cycle (no stall): redirect, service, reti.
    task automatic finish_service();
        tick();
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_wr = 1'b1; mask_data = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic write_gie(input logic g);
        gie_wr = 1'b1; gie_data = g;
        tick();
        gie_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_chk++;
        if ({int_ask, int_vec_valid, in_service} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000", {int_ask, int_vec_valid, in_service});
        end
        n_chk++;
        if (int_vec !== 32'h100 || epc !== 32'h0 || int_id !== 3'd0) begin
            n_fail++; $display("FAIL reset_regs: vec=%h epc=%h id=%0d want 100/0/0", int_vec, epc, int_id);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        write_mask(8'h00);
        write_gie(1'b1);
        irq_in[3] = 1'b1; cur_pc = 32'h40;
        push_exp(3'd3, 32'h40);
        wait_ask(5, n);
        irq_in = '0;
        n_chk++;
        if (n !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", n); end
        n_chk++;
        if (int_id !== 3'd3 || in_service !== 1'b1) begin
            n_fail++; $display("FAIL basic_flush: id=%0d in_service=%b want 3/1", int_id, in_service);
        end
        tick();
        n_chk++;
        if (int_ask !== 1'b0 || int_vec_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_redirect: ask=%b valid=%b want 0/1", int_ask, int_vec_valid);
        end
        repeat (3) tick();
        n_chk++;
        if (in_service !== 1'b1 || int_vec_valid !== 1'b0 || int_vec !== 32'h10C) begin
            n_fail++; $display("FAIL basic_service: in_service=%b valid=%b vec=%h want 1/0/10c", in_service, int_vec_valid, int_vec);
        end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_chk++;
        if (in_service !== 1'b0) begin n_fail++; $display("FAIL basic_reti: in_service=%b want 0", in_service); end
    endtask

    task automatic test_priority();
        int n;
        irq_in = 8'b0010_0010; cur_pc = 32'h50;
        push_exp(3'd1, 32'h50);
        wait_ask(5, n);
        irq_in = '0;
        n_chk++;
        if (n !== 2 || int_id !== 3'd1) begin
            n_fail++; $display("FAIL prio_first: n=%0d id=%0d want 2/1", n, int_id);
        end
        tick();
        tick();
        cur_pc = 32'h60;
        push_exp(3'd5, 32'h60);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        wait_ask(5, n);
        n_chk++;
        if (n + 1 !== 2 || int_id !== 3'd5) begin
            n_fail++; $display("FAIL prio_second: cycles_after_reti=%0d id=%0d want 2/5", n + 1, int_id);
        end
        finish_service();
    endtask

    task automatic test_stall();
        int n;
        int n_ask;
        pipe_stall = 1'b1; cur_pc = 32'h80;
        irq_in[3] = 1'b1;
        wait_ask(5, n);
        irq_in = '0;
        n_chk++;
        if (n !== 2) begin n_fail++; $display("FAIL stall_latency: got %0d want 2", n); end
        n_ask = 1;
        repeat (4) begin
            tick();
            if (int_ask) n_ask++;
        end
        pipe_stall = 1'b0; cur_pc = 32'h88;
        push_exp(3'd3, 32'h88);
        tick();
        n_chk++;
        if (n_ask !== 5 || int_ask !== 1'b0 || int_vec_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_ask_len: ask_cycles=%0d ask=%b valid=%b want 5/0/1", n_ask, int_ask, int_vec_valid);
        end
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic test_mask_gie();
        int n;
        write_mask(8'h04);
        irq_in[2] = 1'b1; cur_pc = 32'hA0;
        wait_ask(6, n);
        irq_in = '0;
        n_chk++;
        if (n !== 7 || in_service !== 1'b0) begin
            n_fail++; $display("FAIL mask_block: ask_after=%0d in_service=%b want none/0", n, in_service);
        end
        push_exp(3'd2, 32'hA0);
        write_mask(8'h00);
        wait_ask(5, n);
        n_chk++;
        if (n + 1 !== 2 || int_id !== 3'd2) begin
            n_fail++; $display("FAIL mask_release: cycles_after_write=%0d id=%0d want 2/2", n + 1, int_id);
        end
        finish_service();
        write_gie(1'b0);
        irq_in[4] = 1'b1; cur_pc = 32'hB0;
        wait_ask(6, n);
        irq_in = '0;
        n_chk++;
        if (n !== 7) begin n_fail++; $display("FAIL gie_block: ask_after=%0d want none", n); end
        push_exp(3'd4, 32'hB0);
        write_gie(1'b1);
        wait_ask(5, n);
        n_chk++;
        if (n + 1 !== 2 || int_id !== 3'd4) begin
            n_fail++; $display("FAIL gie_release: cycles_after_write=%0d id=%0d want 2/4", n + 1, int_id);
        end
        finish_service();
    endtask

    task automatic test_retrigger();
        int n;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_chk++;
        if (in_service !== 1'b0 || int_ask !== 1'b0) begin
            n_fail++; $display("FAIL reti_idle: in_service=%b ask=%b want 0/0", in_service, int_ask);
        end
        irq_in[3] = 1'b1; cur_pc = 32'h70;
        push_exp(3'd3, 32'h70);
        wait_ask(5, n);
        irq_in = '0;
        tick();
        tick();
        irq_in[3] = 1'b1; cur_pc = 32'h74;
        push_exp(3'd3, 32'h74);
        tick();
        irq_in = '0;
        wait_ask(5, n);
        n_chk++;
        if (n !== 6 || in_service !== 1'b1) begin
            n_fail++; $display("FAIL no_nesting: ask_after=%0d in_service=%b want none/1", n, in_service);
        end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        wait_ask(5, n);
        n_chk++;
        if (n + 1 !== 2 || int_id !== 3'd3) begin
            n_fail++; $display("FAIL retake: cycles_after_reti=%0d id=%0d want 2/3", n + 1, int_id);
        end
        finish_service();
    endtask

    task automatic test_reset_mid();
        int n;
        irq_in = 8'hC0; cur_pc = 32'h90;
        push_exp(3'd6, 32'h90);
        wait_ask(5, n);
        irq_in = '0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({int_ask, int_vec_valid, in_service} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_strobes: got %b want 000", {int_ask, int_vec_valid, in_service});
        end
        n_chk++;
        if (int_vec !== 32'h100 || epc !== 32'h0 || int_id !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_regs: vec=%h epc=%h id=%0d want 100/0/0", int_vec, epc, int_id);
        end
        tick();
        tick();
        rst_n = 1'b1;
        write_gie(1'b1);
        irq_in[0] = 1'b1; cur_pc = 32'hC0;
        wait_ask(6, n);
        irq_in = '0;
        n_chk++;
        if (n !== 7) begin n_fail++; $display("FAIL rst_mask_ones: ask_after=%0d want none", n); end
        push_exp(3'd0, 32'hC0);
        write_mask(8'h00);
        wait_ask(5, n);
        n_chk++;
        if (n + 1 !== 2 || int_id !== 3'd0) begin
            n_fail++; $display("FAIL rst_line0: cycles_after_write=%0d id=%0d want 2/0", n + 1, int_id);
        end
        finish_service();
        wait_ask(5, n);
        n_chk++;
        if (n !== 6) begin n_fail++; $display("FAIL rst_pending_cleared: ask_after=%0d want none", n); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        irq_in     = '0;
        mask_wr    = 1'b0;
        mask_data  = '0;
        gie_wr     = 1'b0;
        gie_data   = 1'b0;
        pipe_stall = 1'b0;
        cur_pc     = '0;
        reti       = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_stall();
        test_mask_gie();
        test_retrigger();
        test_reset_mid();
        repeat (2) tick();
        n_chk++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL sb_leftover: %0d expected redirects never seen, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
